// File: rtl/score_keeper.sv
// Per-round event accumulator for both tanks: edge-detected deaths, gold and
// base strikes with saturation, sticky base flags and a post-death respawn lockout.
module score_keeper #(
  parameter int unsigned RESPAWN_CYCLES = 25_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       idle,
  input  logic       enable_game,
  input  logic       tank_hit1,
  input  logic       tank_hit2,
  input  logic       gold_pick1,
  input  logic       gold_pick2,
  input  logic       base_hit1,
  input  logic       base_hit2,
  output logic [1:0] deathcount1,
  output logic [1:0] deathcount2,
  output logic [2:0] num_of_gold1,
  output logic [2:0] num_of_gold2,
  output logic       mother_base_1,
  output logic       mother_base_2,
  output logic       respawn1,
  output logic       respawn2
);

  localparam int unsigned LW = $clog2(RESPAWN_CYCLES + 1);

  logic [1:0]    hit, gold, base;
  logic [1:0]    hit_prev_q, gold_prev_q, base_prev_q;
  logic [1:0]    hit_rise, gold_rise, base_rise;
  logic [1:0]    death_ok;

  logic [1:0]    dc_q   [2];
  logic [1:0]    dc_d   [2];
  logic [2:0]    gold_q [2];
  logic [2:0]    gold_d [2];
  logic [LW-1:0] lock_q [2];
  logic [LW-1:0] lock_d [2];
  logic [1:0]    base_q, base_d;

  assign hit  = {tank_hit2, tank_hit1};
  assign gold = {gold_pick2, gold_pick1};
  assign base = {base_hit2, base_hit1};

  assign hit_rise  = hit  & ~hit_prev_q;
  assign gold_rise = gold & ~gold_prev_q;
  assign base_rise = base & ~base_prev_q;

  // Next-state for both tanks; round clear overrides every event.
  always_comb begin
    death_ok = '0;
    base_d   = base_q;
    for (int i = 0; i < 2; i++) begin
      dc_d[i]   = dc_q[i];
      gold_d[i] = gold_q[i];
      lock_d[i] = lock_q[i];
    end
    if (idle) begin
      base_d = '0;
      for (int i = 0; i < 2; i++) begin
        dc_d[i]   = '0;
        gold_d[i] = '0;
        lock_d[i] = '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        death_ok[i] = enable_game & hit_rise[i] & (lock_q[i] == '0) & (dc_q[i] != 2'd3);
        if (death_ok[i]) begin
          dc_d[i]   = dc_q[i] + 2'd1;
          lock_d[i] = LW'(RESPAWN_CYCLES);
        end else if (lock_q[i] != '0) begin
          lock_d[i] = lock_q[i] - LW'(1);
        end
        // A dead tank cannot pick up gold, including on the cycle it dies.
        if (enable_game & gold_rise[i] & (lock_q[i] == '0) & ~death_ok[i] &
            (gold_q[i] != 3'd7)) begin
          gold_d[i] = gold_q[i] + 3'd1;
        end
        if (enable_game & base_rise[i]) begin
          base_d[i] = 1'b1;
        end
      end
    end
  end

  // Edge-detect history tracks the inputs even through reset and idle.
  always_ff @(posedge clk) begin
    hit_prev_q  <= hit;
    gold_prev_q <= gold;
    base_prev_q <= base;
    if (reset) begin
      base_q <= '0;
      for (int i = 0; i < 2; i++) begin
        dc_q[i]   <= '0;
        gold_q[i] <= '0;
        lock_q[i] <= '0;
      end
    end else begin
      base_q <= base_d;
      for (int i = 0; i < 2; i++) begin
        dc_q[i]   <= dc_d[i];
        gold_q[i] <= gold_d[i];
        lock_q[i] <= lock_d[i];
      end
    end
  end

  assign deathcount1   = dc_q[0];
  assign deathcount2   = dc_q[1];
  assign num_of_gold1  = gold_q[0];
  assign num_of_gold2  = gold_q[1];
  assign mother_base_1 = base_q[0];
  assign mother_base_2 = base_q[1];
  assign respawn1      = (lock_q[0] != '0);
  assign respawn2      = (lock_q[1] != '0);

endmodule
